// File: rtl/ram_stream_pkg.sv
// Shared types and sizing for the RAM read-side streamer.
// Holds the sequencer state encoding and the output buffer geometry.
package ram_stream_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    localparam int BUF_DEPTH = 2;
    localparam int BUF_PTR_W = $clog2(BUF_DEPTH);
    localparam int BUF_CW    = $clog2(BUF_DEPTH + 1);

    // Length field is one bit wider than the address so a full-memory transfer fits.
    function automatic int calc_lw(input int awo);
        return awo + 1;
    endfunction

endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry synchronous FIFO carrying a data word plus a last sideband bit.
// Head entry is presented combinationally; simultaneous push and pop is allowed.
module rd_skid_fifo
    import ram_stream_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DW-1:0]     push_data,
    input  logic              push_last,
    input  logic              pop,
    output logic [DW-1:0]     head_data,
    output logic              head_last,
    output logic              head_valid,
    output logic [BUF_CW-1:0] count
);

    logic [DW-1:0]        data_mem [BUF_DEPTH];
    logic                 last_mem [BUF_DEPTH];
    logic [BUF_PTR_W-1:0] wr_ptr;
    logic [BUF_PTR_W-1:0] rd_ptr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_mem[i] <= '0;
                last_mem[i] <= 1'b0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= push_data;
                last_mem[wr_ptr] <= push_last;
                wr_ptr           <= wr_ptr + BUF_PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + BUF_PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + BUF_CW'(1);
                2'b01:   count <= count - BUF_CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head_data  = data_mem[rd_ptr];
    assign head_last  = last_mem[rd_ptr];
    assign head_valid = (count != '0);

endmodule

// File: rtl/ram_rd_streamer.sv
// Walks a contiguous RAM read range on command and streams the words out as
// valid/ready with a last marker, hiding the RAM's one-cycle read latency.
module ram_rd_streamer
    import ram_stream_pkg::*;
#(
    parameter int DWO = 16,
    parameter int AWO = 6,
    parameter int LW  = calc_lw(AWO)
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [AWO-1:0] start_addr,
    input  logic [LW-1:0]  start_len,
    output logic           busy,
    output logic           done,
    output logic [AWO-1:0] rd_addr,
    input  logic [DWO-1:0] rd_data,
    output logic [DWO-1:0] m_data,
    output logic           m_valid,
    input  logic           m_ready,
    output logic           m_last
);

    localparam int OW = BUF_CW + 1;

    state_t            state;
    state_t            state_next;
    logic [LW-1:0]     issue_cnt;
    logic              inflight;
    logic              inflight_last;
    logic [BUF_CW-1:0] buf_count;
    logic [DWO-1:0]    buf_data;
    logic              buf_last;
    logic              buf_valid;
    logic [OW-1:0]     occupancy;
    logic              pop;
    logic              accept;
    logic              zero_cmd;
    logic              issue;
    logic              final_issue;
    logic              last_hs;

    // Occupancy after this edge counts the word already in flight, so two slots never overflow.
    always_comb begin
        pop         = buf_valid & m_ready;
        accept      = (state == IDLE) && start && (start_len != '0);
        zero_cmd    = (state == IDLE) && start && (start_len == '0);
        occupancy   = {1'b0, buf_count} + OW'(inflight) - OW'(pop);
        issue       = (state == RUN) && (occupancy < OW'(BUF_DEPTH));
        final_issue = issue && (issue_cnt == LW'(1));
        last_hs     = pop && buf_last;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)      state_next = RUN;
            RUN:     if (final_issue) state_next = DRAIN;
            DRAIN:   if (last_hs)     state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    // The address loaded on start is the first read; each later issue advances it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_addr       <= '0;
            issue_cnt     <= '0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            done          <= 1'b0;
        end else begin
            if (accept) begin
                rd_addr   <= start_addr;
                issue_cnt <= start_len;
            end else if (issue) begin
                rd_addr   <= rd_addr + AWO'(1);
                issue_cnt <= issue_cnt - LW'(1);
            end
            inflight      <= issue;
            inflight_last <= final_issue;
            done          <= zero_cmd || ((state == DRAIN) && last_hs);
        end
    end

    rd_skid_fifo #(
        .DW (DWO)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (inflight),
        .push_data  (rd_data),
        .push_last  (inflight_last),
        .pop        (pop),
        .head_data  (buf_data),
        .head_last  (buf_last),
        .head_valid (buf_valid),
        .count      (buf_count)
    );

    always_comb begin
        busy    = (state != IDLE);
        m_valid = buf_valid;
        m_data  = buf_data;
        m_last  = buf_valid & buf_last;
    end

endmodule

// File: tb/tb_ram_rd_streamer.sv
// Self-checking bench for ram_rd_streamer: a queue-based model of the expected
// word stream, checked every cycle, plus literal expectations for directed cases.
module tb_ram_rd_streamer;

    typedef struct packed {
        logic [15:0] data;
        logic        last;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [5:0]  start_addr;
    logic [6:0]  start_len;
    logic        busy;
    logic        done;
    logic [5:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    logic [15:0] mem [64];
    exp_t        exp_q [$];
    logic [15:0] got [$];

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int done_count = 0;
    int hs_count   = 0;
    int start_cyc  = 0;
    int last_hs_cyc = 0;
    int ready_mode = 0;

    logic        model_busy = 1'b0;
    logic        exp_done   = 1'b0;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_data  = '0;
    logic        prev_last  = 1'b0;

    ram_rd_streamer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .start_addr (start_addr),
        .start_len  (start_len),
        .busy       (busy),
        .done       (done),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_last     (m_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc     <= cyc + 1;
        rd_data <= mem[rd_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: every accepted command appends its words to the queue in address order.
    always @(negedge clk) begin
        logic next_done;
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            model_busy = 1'b0;
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            checkOutput("busy", 32'(busy), 32'(model_busy));
            checkOutput("done", 32'(done), 32'(exp_done));
            if (done) done_count++;
            if (prev_stall) begin
                checkOutput("stall_valid", 32'(m_valid), 32'd1);
                checkOutput("stall_data", 32'(m_data), 32'(prev_data));
                checkOutput("stall_last", 32'(m_last), 32'(prev_last));
            end
            if (m_valid && exp_q.size() == 0)
                checkOutput("spurious_valid", 32'(m_valid), 32'd0);
            next_done = 1'b0;
            if (m_valid && m_ready && exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checkOutput("stream_data", 32'(m_data), 32'(e.data));
                checkOutput("stream_last", 32'(m_last), 32'(e.last));
                got.push_back(m_data);
                hs_count++;
                if (e.last) begin
                    next_done   = 1'b1;
                    model_busy  = 1'b0;
                    last_hs_cyc = cyc;
                end
            end else if (start && !model_busy) begin
                if (start_len == 0) begin
                    next_done = 1'b1;
                end else begin
                    for (int i = 0; i < int'(start_len); i++) begin
                        logic [5:0] a;
                        a = start_addr + 6'(i);
                        e.data = mem[a];
                        e.last = (i == int'(start_len) - 1);
                        exp_q.push_back(e);
                    end
                    model_busy = 1'b1;
                    start_cyc  = cyc;
                end
            end
            exp_done   = next_done;
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    // Consumer: always ready, a 1,0,0,1 pattern, or random.
    initial begin
        int phase;
        phase   = 0;
        m_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0: m_ready = 1'b1;
                1: begin
                    m_ready = (phase == 0) || (phase == 3);
                    phase   = (phase + 1) % 4;
                end
                default: m_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic applyStimulus(input logic [5:0] addr, input logic [6:0] len);
        @(posedge clk);
        #1;
        start      = 1'b1;
        start_addr = addr;
        start_len  = len;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input int budget);
        int base;
        int n;
        base = done_count;
        n    = 0;
        while (done_count == base && n < budget) begin
            @(posedge clk);
            n++;
        end
        checkOutput("done_timeout", 32'(done_count != base), 32'd1);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [5:0] addr_before;
        int         base;
        rst_n      = 1'b0;
        start      = 1'b0;
        start_addr = '0;
        start_len  = '0;
        for (int a = 0; a < 64; a++) mem[a] = 16'(a * 16'h0101);

        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_rd_addr", 32'(rd_addr), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_m_last", 32'(m_last), 32'd0);
        checkOutput("rst_m_data", 32'(m_data), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("[TB] basic transfer addr=0x05 len=4");
        ready_mode = 0;
        got.delete();
        applyStimulus(6'h05, 7'd4);
        waitDone(40);
        checkOutput("t1_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            checkOutput("t1_w0", 32'(got[0]), 32'h0505);
            checkOutput("t1_w1", 32'(got[1]), 32'h0606);
            checkOutput("t1_w2", 32'(got[2]), 32'h0707);
            checkOutput("t1_w3", 32'(got[3]), 32'h0808);
        end
        checkOutput("t1_latency", 32'(last_hs_cyc - start_cyc), 32'd6);

        $display("[TB] address wrap addr=0x3E len=4");
        got.delete();
        applyStimulus(6'h3E, 7'd4);
        waitDone(40);
        checkOutput("t2_count", 32'(got.size()), 32'd4);
        if (got.size() == 4) begin
            checkOutput("t2_w0", 32'(got[0]), 32'h3E3E);
            checkOutput("t2_w1", 32'(got[1]), 32'h3F3F);
            checkOutput("t2_w2", 32'(got[2]), 32'h0000);
            checkOutput("t2_w3", 32'(got[3]), 32'h0101);
        end

        $display("[TB] backpressure len=8 ready 1,0,0,1");
        ready_mode = 1;
        got.delete();
        applyStimulus(6'h20, 7'd8);
        waitDone(100);
        checkOutput("t3_count", 32'(got.size()), 32'd8);
        for (int i = 0; i < got.size(); i++)
            checkOutput("t3_word", 32'(got[i]), 32'(16'h2020 + 16'(i) * 16'h0101));
        ready_mode = 0;

        $display("[TB] zero length command");
        repeat (2) @(posedge clk);
        addr_before = rd_addr;
        applyStimulus(6'h11, 7'd0);
        checkOutput("t4_done", 32'(done), 32'd1);
        checkOutput("t4_busy", 32'(busy), 32'd0);
        checkOutput("t4_valid", 32'(m_valid), 32'd0);
        checkOutput("t4_rd_addr", 32'(rd_addr), 32'(addr_before));
        repeat (3) @(posedge clk);

        $display("[TB] start while busy is ignored");
        base = done_count;
        got.delete();
        applyStimulus(6'h10, 7'd6);
        repeat (2) @(posedge clk);
        applyStimulus(6'h30, 7'd3);
        waitDone(40);
        repeat (6) @(posedge clk);
        checkOutput("t5_done_pulses", 32'(done_count - base), 32'd1);
        checkOutput("t5_count", 32'(got.size()), 32'd6);
        if (got.size() == 6) checkOutput("t5_last_word", 32'(got[5]), 32'h1515);

        $display("[TB] reset mid-transfer");
        base = hs_count;
        applyStimulus(6'h00, 7'd10);
        begin
            int guard;
            guard = 0;
            while (hs_count < base + 3 && guard < 50) begin
                @(posedge clk);
                guard++;
            end
            checkOutput("t6_reach3", 32'(hs_count >= base + 3), 32'd1);
        end
        #1;
        base  = done_count;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_valid", 32'(m_valid), 32'd0);
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        checkOutput("t6_no_done", 32'(done_count - base), 32'd0);
        got.delete();
        applyStimulus(6'h08, 7'd2);
        waitDone(40);
        checkOutput("t6_count", 32'(got.size()), 32'd2);
        if (got.size() == 2) begin
            checkOutput("t6_w0", 32'(got[0]), 32'h0808);
            checkOutput("t6_w1", 32'(got[1]), 32'h0909);
        end

        $display("[TB] randomized transfers");
        for (int a = 0; a < 64; a++) mem[a] = 16'($urandom);
        for (int t = 0; t < 14; t++) begin
            logic [6:0] len;
            ready_mode = $urandom_range(0, 2);
            len = ($urandom_range(0, 7) == 0) ? 7'd0 : 7'($urandom_range(1, 64));
            if (t == 0) len = 7'd64;
            applyStimulus(6'($urandom_range(0, 63)), len);
            if (len == 0) repeat (2) @(posedge clk);
            else waitDone(64 * 6 + 20);
        end
        ready_mode = 0;
        repeat (4) @(posedge clk);
        checkOutput("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
